// File: rtl/padded_window_read_sched.sv
// Read scheduler for the padded line buffer: turns line_done credits into KH-row window bursts.
// Optional ring addressing and line release enabled by defining PWRS_RING_BUF_EN.
module padded_window_read_sched #(
  parameter int KH    = 3,
  parameter int LINES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] cfg_c,
  input  logic [10:0] cfg_w,
  input  logic [10:0] cfg_h,
  input  logic        padding,
  input  logic [31:0] base_addr,
  input  logic        line_done,
  input  logic        rd_ready,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  output logic        rd_first,
  output logic        rd_last,
  output logic        line_release,
  output logic        busy,
  output logic        done
);

  localparam int KW = (KH > 1) ? $clog2(KH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_BURST, S_ROW_ADV, S_DRAIN, S_DONE
  } state_t;

  state_t        state_q;
  logic [17:0]   rw_q;
  logic [11:0]   hp_q, ho_q, out_row_q, line_cnt_q;
  logic [17:0]   col_q;
  logic [KW-1:0] k_q;
  logic [31:0]   base_w_q, win_base_q, cur_base_q;
  logic          rd_en_q, rd_first_q, rd_last_q, line_release_q, busy_q, done_q;
  logic [31:0]   rd_addr_q;

  // Job parameters derived from the config inputs at start.
  logic [11:0] wp_d, hp_d, ho_d;
  logic [21:0] prod_d;
  logic [17:0] row_words_d;
  logic [31:0] rw_ext, nxt_cur_base_d, nxt_win_base_d;
  logic        last_col, last_k, credit_ok;

  assign wp_d        = {1'b0, cfg_w} + (padding ? 12'd2 : 12'd0);
  assign hp_d        = {1'b0, cfg_h} + (padding ? 12'd2 : 12'd0);
  assign prod_d      = 22'({11'b0, cfg_c} * {10'b0, wp_d});
  assign row_words_d = 18'(prod_d >> 4);
  assign ho_d        = (hp_d < 12'(KH)) ? 12'd0 : hp_d - 12'(KH) + 12'd1;
  assign rw_ext      = {14'b0, rw_q};
  assign last_col    = (col_q == rw_q - 18'd1);
  assign last_k      = (k_q == KW'(KH - 1));

`ifdef PWRS_RING_BUF_EN
  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
  logic [LW-1:0] win_idx_q, cur_idx_q;
  logic [11:0]   released_q;
  logic [KW-1:0] drain_q;

  // Row bases wrap back to base_w instead of using a modulo.
  assign nxt_cur_base_d = (cur_idx_q == LW'(LINES - 1)) ? base_w_q : cur_base_q + rw_ext;
  assign nxt_win_base_d = (win_idx_q == LW'(LINES - 1)) ? base_w_q : win_base_q + rw_ext;
  assign credit_ok      = ((line_cnt_q - released_q) >= 12'(KH));
`else
  assign nxt_cur_base_d = cur_base_q + rw_ext;
  assign nxt_win_base_d = win_base_q + rw_ext;
  assign credit_ok      = ({1'b0, line_cnt_q} >= ({1'b0, out_row_q} + 13'(KH)));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      rw_q           <= '0;
      hp_q           <= '0;
      ho_q           <= '0;
      out_row_q      <= '0;
      line_cnt_q     <= '0;
      col_q          <= '0;
      k_q            <= '0;
      base_w_q       <= '0;
      win_base_q     <= '0;
      cur_base_q     <= '0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      rd_first_q     <= 1'b0;
      rd_last_q      <= 1'b0;
      line_release_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
`ifdef PWRS_RING_BUF_EN
      win_idx_q      <= '0;
      cur_idx_q      <= '0;
      released_q     <= '0;
      drain_q        <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && line_done && line_cnt_q < hp_q)
        line_cnt_q <= line_cnt_q + 12'd1;
`ifdef PWRS_RING_BUF_EN
      if (line_release_q)
        released_q <= released_q + 12'd1;
`endif
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rw_q       <= row_words_d;
            hp_q       <= hp_d;
            ho_q       <= ho_d;
            base_w_q   <= base_addr >> 4;
            win_base_q <= base_addr >> 4;
            line_cnt_q <= {11'b0, line_done && (hp_d != 12'd0)};
            out_row_q  <= '0;
            col_q      <= '0;
            k_q        <= '0;
            busy_q     <= 1'b1;
`ifdef PWRS_RING_BUF_EN
            win_idx_q  <= '0;
            released_q <= '0;
`endif
            state_q    <= (ho_d == 12'd0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (credit_ok) begin
            state_q    <= S_BURST;
            rd_en_q    <= 1'b1;
            rd_addr_q  <= win_base_q;
            cur_base_q <= win_base_q;
            col_q      <= '0;
            k_q        <= '0;
            rd_first_q <= 1'b1;
            rd_last_q  <= (KH == 1) && (rw_q == 18'd1);
`ifdef PWRS_RING_BUF_EN
            cur_idx_q  <= win_idx_q;
`endif
          end
        end
        S_BURST: begin
          // Outputs only advance on a transfer, so they hold while stalled.
          if (rd_ready) begin
            rd_first_q <= 1'b0;
            if (last_col) begin
              col_q <= '0;
              if (last_k) begin
                k_q       <= '0;
                rd_en_q   <= 1'b0;
                rd_last_q <= 1'b0;
                state_q   <= S_ROW_ADV;
`ifdef PWRS_RING_BUF_EN
                line_release_q <= 1'b1;
`endif
              end else begin
                k_q        <= k_q + KW'(1);
                cur_base_q <= nxt_cur_base_d;
                rd_addr_q  <= nxt_cur_base_d;
                rd_last_q  <= (k_q == KW'(KH - 2)) && (rw_q == 18'd1);
`ifdef PWRS_RING_BUF_EN
                cur_idx_q  <= (cur_idx_q == LW'(LINES - 1)) ? '0 : cur_idx_q + LW'(1);
`endif
              end
            end else begin
              col_q     <= col_q + 18'd1;
              rd_addr_q <= rd_addr_q + 32'd1;
              rd_last_q <= last_k && (col_q + 18'd1 == rw_q - 18'd1);
            end
          end
        end
        S_ROW_ADV: begin
          out_row_q  <= out_row_q + 12'd1;
          win_base_q <= nxt_win_base_d;
`ifdef PWRS_RING_BUF_EN
          win_idx_q  <= (win_idx_q == LW'(LINES - 1)) ? '0 : win_idx_q + LW'(1);
`endif
          if (out_row_q == ho_q - 12'd1) begin
`ifdef PWRS_RING_BUF_EN
            // The last window still owns KH-1 rows; free them before finishing.
            if (KH > 1) begin
              state_q        <= S_DRAIN;
              drain_q        <= KW'(KH - 2);
              line_release_q <= 1'b1;
            end else begin
              state_q        <= S_DONE;
              line_release_q <= 1'b0;
            end
`else
            state_q <= S_DONE;
`endif
          end else begin
            state_q        <= S_WAIT;
            line_release_q <= 1'b0;
          end
        end
        S_DRAIN: begin
`ifdef PWRS_RING_BUF_EN
          if (drain_q == '0) begin
            line_release_q <= 1'b0;
            state_q        <= S_DONE;
          end else begin
            drain_q        <= drain_q - KW'(1);
            line_release_q <= 1'b1;
          end
`else
          state_q <= S_DONE;
`endif
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign rd_first     = rd_first_q;
  assign rd_last      = rd_last_q;
  assign line_release = line_release_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
